stack_sequencer: RTL and testbench
==================================

# stack_sequencer

Instruction sequencer that sits directly upstream of `stack_register` in the stack calculator. It accepts one 4-bit opcode plus a 4-bit immediate per handshake, checks the operands against a tracked stack depth, and computes ALU results from the two top stack words. It then drives the register's `mode`/`in_word` inputs through a 1–3 cycle command sequence per instruction.

## Interface
- `STACK_SIZE`, default `` `STACK_SIZE `` (from `constants.v`): stack depth in words; sets the depth counter range.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `op_valid`  in  1  opcode/immediate present.
- `op_ready`  out  1  sequencer idle and able to accept.
- `op`  in  4  opcode.
- `imm`  in  4  immediate, used by PUSH only.
- `top_word`  in  4  stack entry 0, from `stack_register`.
- `second_word`  in  4  stack entry 1, from `stack_register`.
- `stack_mode`  out  3  command to `stack_register`; registered.
- `stack_in`  out  4  word to `stack_register`; registered.
- `depth`  out  ceil(log2(STACK_SIZE+1))  number of valid entries.
- `carry`  out  1  carry from the last ADD, or borrow from the last SUB.
- `err_underflow`  out  1  one-cycle pulse: instruction rejected because the stack had too few entries.
- `err_overflow`  out  1  one-cycle pulse: instruction rejected because the stack was full.
- `err_illegal`  out  1  one-cycle pulse: unknown opcode rejected.

## Operation
- Stack commands: HOLD=0, PUSH=1 (shift down, `in_word` goes to entry 0), POP=2 (shift up), REPLACE=3 (load entry 0, other entries hold).
- Opcodes, with required depth → command sequence → depth change:
  - NOP 0: no stack commands.
  - PUSH 1: needs depth < STACK_SIZE → PUSH(imm) → +1.
  - POP 2: needs ≥1 → POP → −1.
  - DUP 3: needs ≥1 and < STACK_SIZE → PUSH(top) → +1.
  - SWAP 4: needs ≥2 → POP, REPLACE(t), PUSH(s) → 0, where t/s are top/second latched at accept.
  - ADD 5, SUB 6, AND 7, OR 8, XOR 9: need ≥2 → POP, REPLACE(r) → −1.
  - NOT 10: needs ≥1 → REPLACE(~top) → 0.
  - Opcodes 11–15 are illegal.
- Arithmetic rules:
  - All arithmetic is modulo 16.
  - SUB computes second − top.
  - `carry` = bit 4 of the 5-bit sum for ADD, or borrow for SUB; no other opcode changes it.
- FSM states: IDLE, CMD1, CMD2, CMD3.
  - Accept happens in IDLE when `op_valid & op_ready`.
  - The result r and the latched t/s are captured from `top_word`/`second_word` at the accept edge.
  - A legal op moves to CMD1 with its first command registered.
  - Each CMDn presents one command for one cycle, then advances to CMD(n+1) or back to IDLE after the last command.
  - `stack_mode` is HOLD in IDLE.
- Rejected ops:
  - Covers NOP, illegal opcodes, underflow and overflow.
  - The op is consumed in one cycle and the FSM stays in IDLE.
  - No stack command is issued and `depth` is unchanged.
  - The matching error flag pulses in the following cycle.
  - When several checks fail, priority is illegal > underflow > overflow.
- `depth` updates at the same edge the final command executes.
- Reset values: IDLE; `op_ready`=1, `stack_mode`=HOLD, `stack_in`=0, `depth`=0, `carry`=0, all error flags 0.
- Reset mid-sequence abandons the remaining commands. Stack contents are undefined afterwards and are treated as empty (depth 0).

## Timing
- Accept edge E → first command presented during cycle E+1 → `stack_register` updates at edge E+1.
- `op_ready` is low from E until the cycle after the last command.
- Per-instruction occupancy: 1 cycle for rejected ops and NOP; 2 for PUSH/POP/DUP/NOT; 3 for binary ops; 4 for SWAP.
- The result is visible on `top_word` after the last command edge. The next op may be accepted in that same cycle and sees the updated stack.
- `op_valid` is ignored while `op_ready` is low. A producer holds `op`/`imm` until accepted.

## Structure
- Shared `constants.v` holds the stack command codes, opcode codes and `` `STACK_SIZE ``; `stack_register` uses the same command codes.
- Natural sub-module: `stack_alu`.
  - Combinational: (op, top, second) → 4-bit result plus carry.
  - Instantiated once, sampled at accept.
- The FSM, depth counter and legality checks stay in `stack_sequencer`.
- The bench instantiates `stack_sequencer` + `stack_register` together.

## Test plan
- Reset, then PUSH 3, PUSH 5, ADD → top=8, depth=1, carry=0; ADD occupies `op_ready` low for exactly 2 cycles.
- PUSH 9, PUSH 12, ADD → top=5, carry=1; then PUSH 7, SUB → top=14 (5−7), carry=1.
- PUSH 1, PUSH 2, SWAP → top=1, second=2, depth=2, with the command sequence POP, REPLACE(2), PUSH(1) on consecutive cycles.
- Boundaries:
  - After reset, POP → `err_underflow` pulse, `stack_mode` stays HOLD.
  - Fill to STACK_SIZE with PUSH, then PUSH or DUP → `err_overflow` pulse, depth unchanged.
  - Op 13 → `err_illegal`.
- Assert `rst` in the CMD2 state of a SWAP → next cycle IDLE, depth=0, `stack_mode`=HOLD, `op_ready`=1.
- Hold `op_valid` high with back-to-back ops (PUSH 4, DUP, NOT) → each accepted exactly once; final top=11, second=4.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// Shared definitions for the stack calculator sequencer: stack command
// codes, opcode codes, FSM states and per-opcode property helpers.
package stack_sequencer_pkg;

    localparam int STACK_SIZE_DEFAULT = 8;

    typedef enum logic [2:0] {
        CMD_HOLD    = 3'd0,
        CMD_PUSH    = 3'd1,
        CMD_POP     = 3'd2,
        CMD_REPLACE = 3'd3
    } stack_cmd_e;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_PUSH = 4'd1,
        OP_POP  = 4'd2,
        OP_DUP  = 4'd3,
        OP_SWAP = 4'd4,
        OP_ADD  = 4'd5,
        OP_SUB  = 4'd6,
        OP_AND  = 4'd7,
        OP_OR   = 4'd8,
        OP_XOR  = 4'd9,
        OP_NOT  = 4'd10
    } opcode_e;

    localparam logic [3:0] OP_LAST_LEGAL = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD1 = 2'd1,
        ST_CMD2 = 2'd2,
        ST_CMD3 = 2'd3
    } seq_state_e;

    // Number of stack commands an accepted opcode issues.
    function automatic logic [1:0] cmd_count(input logic [3:0] op);
        case (op)
            OP_PUSH, OP_POP, OP_DUP, OP_NOT:          cmd_count = 2'd1;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:    cmd_count = 2'd2;
            OP_SWAP:                                  cmd_count = 2'd3;
            default:                                  cmd_count = 2'd0;
        endcase
    endfunction

    // Minimum number of stack entries the opcode consumes.
    function automatic logic [1:0] min_depth(input logic [3:0] op);
        case (op)
            OP_POP, OP_DUP, OP_NOT:                            min_depth = 2'd1;
            OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:    min_depth = 2'd2;
            default:                                           min_depth = 2'd0;
        endcase
    endfunction

    // True when the opcode leaves one more entry on the stack.
    function automatic logic grows(input logic [3:0] op);
        case (op)
            OP_PUSH, OP_DUP: grows = 1'b1;
            default:         grows = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stack_sequencer_alu.sv
// Combinational ALU: derives the result word and carry/borrow from the
// two top stack words. SUB is second - top; carry is only meaningful
// for ADD and SUB.
module stack_sequencer_alu
    import stack_sequencer_pkg::*;
(
    input  logic [3:0] op,
    input  logic [3:0] top,
    input  logic [3:0] second,
    output logic [3:0] result,
    output logic       carry
);

    logic [4:0] wide_s;

    // Select the operation; ADD/SUB use a 5-bit datapath for carry/borrow.
    always_comb begin
        wide_s = 5'd0;
        result = 4'd0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                wide_s = {1'b0, second} + {1'b0, top};
                result = wide_s[3:0];
                carry  = wide_s[4];
            end
            OP_SUB: begin
                wide_s = {1'b0, second} - {1'b0, top};
                result = wide_s[3:0];
                carry  = wide_s[4];
            end
            OP_AND:  result = second & top;
            OP_OR:   result = second | top;
            OP_XOR:  result = second ^ top;
            OP_NOT:  result = ~top;
            default: result = 4'd0;
        endcase
    end

endmodule

// File: rtl/stack_sequencer.sv
// Instruction sequencer in front of stack_register: accepts an opcode,
// checks it against the tracked depth and replays it as a 1-3 cycle
// sequence of registered stack commands.
module stack_sequencer
    import stack_sequencer_pkg::*;
#(
    parameter  int STACK_SIZE = STACK_SIZE_DEFAULT,
    localparam int DW         = $clog2(STACK_SIZE + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          op_valid,
    output logic          op_ready,
    input  logic [3:0]    op,
    input  logic [3:0]    imm,
    input  logic [3:0]    top_word,
    input  logic [3:0]    second_word,
    output logic [2:0]    stack_mode,
    output logic [3:0]    stack_in,
    output logic [DW-1:0] depth,
    output logic          carry,
    output logic          err_underflow,
    output logic          err_overflow,
    output logic          err_illegal
);

    seq_state_e    state_r, state_s;
    logic [3:0]    op_r, t_r, s_r, res_r;
    logic [DW-1:0] target_r, target_s;
    logic [3:0]    alu_res_s;
    logic          alu_carry_s;
    stack_cmd_e    mode_s;
    logic [3:0]    word_s;
    logic          carry_s, go_s, commit_s;
    logic          illegal_s, under_s, over_s;
    logic          ill_s, und_s, ovf_s;

    stack_sequencer_alu u_alu (
        .op     (op),
        .top    (top_word),
        .second (second_word),
        .result (alu_res_s),
        .carry  (alu_carry_s)
    );

    // Legality checks and the depth the instruction will leave behind.
    always_comb begin
        illegal_s = (op > OP_LAST_LEGAL);
        under_s   = (depth < DW'(min_depth(op)));
        over_s    = grows(op) && (depth >= DW'(STACK_SIZE));
        case (op)
            OP_PUSH, OP_DUP:                                target_s = depth + DW'(1);
            OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR:  target_s = depth - DW'(1);
            default:                                        target_s = depth;
        endcase
    end

    // Next state, next stack command and error/commit strobes.
    always_comb begin
        state_s  = state_r;
        mode_s   = CMD_HOLD;
        word_s   = 4'd0;
        carry_s  = carry;
        go_s     = 1'b0;
        commit_s = 1'b0;
        ill_s    = 1'b0;
        und_s    = 1'b0;
        ovf_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    if (illegal_s) begin
                        ill_s = 1'b1;
                    end else if (under_s) begin
                        und_s = 1'b1;
                    end else if (over_s) begin
                        ovf_s = 1'b1;
                    end else if (op == OP_NOP) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_CMD1;
                        go_s    = 1'b1;
                        case (op)
                            OP_PUSH: begin mode_s = CMD_PUSH;    word_s = imm;       end
                            OP_DUP:  begin mode_s = CMD_PUSH;    word_s = top_word;  end
                            OP_NOT:  begin mode_s = CMD_REPLACE; word_s = alu_res_s; end
                            default: begin mode_s = CMD_POP;     word_s = 4'd0;      end
                        endcase
                        if (op == OP_ADD || op == OP_SUB) begin
                            carry_s = alu_carry_s;
                        end else begin
                            carry_s = carry;
                        end
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CMD1: begin
                if (cmd_count(op_r) == 2'd1) begin
                    state_s  = ST_IDLE;
                    commit_s = 1'b1;
                end else begin
                    state_s = ST_CMD2;
                    mode_s  = CMD_REPLACE;
                    word_s  = (op_r == OP_SWAP) ? t_r : res_r;
                end
            end
            ST_CMD2: begin
                if (cmd_count(op_r) == 2'd2) begin
                    state_s  = ST_IDLE;
                    commit_s = 1'b1;
                end else begin
                    state_s = ST_CMD3;
                    mode_s  = CMD_PUSH;
                    word_s  = s_r;
                end
            end
            ST_CMD3: begin
                state_s  = ST_IDLE;
                commit_s = 1'b1;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, registered outputs, operand latches and depth counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            op_ready      <= 1'b1;
            stack_mode    <= CMD_HOLD;
            stack_in      <= 4'd0;
            depth         <= '0;
            carry         <= 1'b0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            err_illegal   <= 1'b0;
            op_r          <= 4'd0;
            t_r           <= 4'd0;
            s_r           <= 4'd0;
            res_r         <= 4'd0;
            target_r      <= '0;
        end else begin
            state_r       <= state_s;
            op_ready      <= (state_s == ST_IDLE);
            stack_mode    <= mode_s;
            stack_in      <= word_s;
            carry         <= carry_s;
            err_underflow <= und_s;
            err_overflow  <= ovf_s;
            err_illegal   <= ill_s;
            if (go_s) begin
                op_r     <= op;
                t_r      <= top_word;
                s_r      <= second_word;
                res_r    <= alu_res_s;
                target_r <= target_s;
            end else begin
                op_r <= op_r;
            end
            if (commit_s) begin
                depth <= target_r;
            end else begin
                depth <= depth;
            end
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: a simple stack register driven by the DUT's
// commands, an instruction-level reference model, directed scenarios and
// a randomized phase.
module tb_stack_sequencer;
    import stack_sequencer_pkg::*;

    localparam int SZ = 8;
    localparam int DW = $clog2(SZ + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic [3:0]    op = 4'd0;
    logic [3:0]    imm = 4'd0;
    logic          op_ready;
    logic [3:0]    top_word, second_word;
    logic [2:0]    stack_mode;
    logic [3:0]    stack_in;
    logic [DW-1:0] depth;
    logic          carry, err_underflow, err_overflow, err_illegal;

    int total = 0;
    int bad = 0;
    int dut_acc = 0;

    always #5 clk = ~clk;

    stack_sequencer #(.STACK_SIZE(SZ)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op(op), .imm(imm), .top_word(top_word), .second_word(second_word),
        .stack_mode(stack_mode), .stack_in(stack_in), .depth(depth),
        .carry(carry), .err_underflow(err_underflow),
        .err_overflow(err_overflow), .err_illegal(err_illegal)
    );

    // Stand-in for stack_register, driven only by the DUT's commands.
    logic [3:0] phys [SZ] = '{default: 4'd0};
    always @(posedge clk) begin
        case (stack_mode)
            3'd1: begin
                for (int i = SZ - 1; i > 0; i--) phys[i] <= phys[i-1];
                phys[0] <= stack_in;
            end
            3'd2: begin
                for (int i = 0; i < SZ - 1; i++) phys[i] <= phys[i+1];
                phys[SZ-1] <= 4'd0;
            end
            3'd3: phys[0] <= stack_in;
            default: ;
        endcase
    end
    assign top_word    = phys[0];
    assign second_word = phys[1];

    // Count accepts as seen at the DUT handshake.
    always @(posedge clk) begin
        if (!rst && op_valid && op_ready) dut_acc <= dut_acc + 1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (instruction level) ----------------
    int mstk[$];        // committed stack, index 0 = top
    int pstk[$];        // stack after the in-flight instruction
    int qm[$], qw[$];   // pending command modes / words
    int m_carry = 0;
    int e_ill = 0, e_und = 0, e_ovf = 0;
    int acc_cnt = 0;
    bit mvalid = 1'b0;

    task automatic decode(input int o, input int im);
        int n, need, t, s, r;
        n = mstk.size();
        need = (o == 2 || o == 3 || o == 10) ? 1 : ((o >= 4 && o <= 9) ? 2 : 0);
        t = (n > 0) ? mstk[0] : 0;
        s = (n > 1) ? mstk[1] : 0;
        r = 0;
        if (o > 10) e_ill = 1;
        else if (n < need) e_und = 1;
        else if ((o == 1 || o == 3) && n >= SZ) e_ovf = 1;
        else if (o != 0) begin
            pstk = mstk;
            case (o)
                1: begin qm.push_back(1); qw.push_back(im); pstk.push_front(im); end
                2: begin qm.push_back(2); qw.push_back(0); void'(pstk.pop_front()); end
                3: begin qm.push_back(1); qw.push_back(t); pstk.push_front(t); end
                4: begin
                    qm.push_back(2); qw.push_back(0);
                    qm.push_back(3); qw.push_back(t);
                    qm.push_back(1); qw.push_back(s);
                    pstk[0] = s; pstk[1] = t;
                end
                10: begin qm.push_back(3); qw.push_back(15 - t); pstk[0] = 15 - t; end
                default: begin
                    case (o)
                        5: begin r = (s + t) % 16; m_carry = (s + t > 15) ? 1 : 0; end
                        6: begin r = (s - t + 16) % 16; m_carry = (s < t) ? 1 : 0; end
                        7: r = s & t;
                        8: r = s | t;
                        default: r = s ^ t;
                    endcase
                    qm.push_back(2); qw.push_back(0);
                    qm.push_back(3); qw.push_back(r);
                    void'(pstk.pop_front());
                    pstk[0] = r;
                end
            endcase
        end
    endtask

    task automatic model_step();
        if (rst) begin
            mstk.delete(); pstk.delete(); qm.delete(); qw.delete();
            m_carry = 0; e_ill = 0; e_und = 0; e_ovf = 0;
            mvalid = 1'b1;
        end else begin
            e_ill = 0; e_und = 0; e_ovf = 0;
            if (qm.size() != 0) begin
                void'(qm.pop_front());
                void'(qw.pop_front());
                if (qm.size() == 0) mstk = pstk;
            end else if (op_valid) begin
                acc_cnt++;
                decode(int'(op), int'(imm));
            end
        end
    endtask

    task automatic compare();
        int em;
        em = (qm.size() != 0) ? qm[0] : 0;
        chk("mode", int'(stack_mode), em);
        if (em != 0) chk("in_word", int'(stack_in), qw[0]);
        chk("ready", int'(op_ready), (qm.size() == 0) ? 1 : 0);
        chk("depth", int'(depth), mstk.size());
        chk("carry", int'(carry), m_carry);
        chk("err_illegal", int'(err_illegal), e_ill);
        chk("err_underflow", int'(err_underflow), e_und);
        chk("err_overflow", int'(err_overflow), e_ovf);
        if (qm.size() == 0) begin
            for (int i = 0; i < 2 && i < mstk.size(); i++)
                chk("stack_entry", int'(phys[i]), mstk[i]);
        end
    endtask

    // Model update at every edge, comparison on the following falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (mvalid) compare();
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input int o, input int im);
        int start;
        bit got;
        op_valid = 1'b1;
        op = 4'(o);
        imm = 4'(im);
        start = acc_cnt;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (acc_cnt != start) begin got = 1'b1; break; end
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        op_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (qm.size() == 0) break;
            @(negedge clk);
        end
        if (qm.size() != 0) chk("idle_timeout", qm.size(), 0);
    endtask

    task automatic run(input int o, input int im);
        issue(o, im);
        wait_idle();
    endtask

    task automatic do_reset();
        op_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lowc, a0;
        repeat (2) @(negedge clk);
        chk("rst_ready", int'(op_ready), 1);
        chk("rst_mode", int'(stack_mode), 0);
        chk("rst_in", int'(stack_in), 0);
        chk("rst_depth", int'(depth), 0);
        chk("rst_carry", int'(carry), 0);
        rst = 1'b0;

        // 3 + 5, and ready stays low exactly two cycles
        run(1, 3); run(1, 5);
        issue(5, 0);
        op_valid = 1'b0;
        lowc = 0;
        for (int k = 0; k < 10; k++) begin
            if (op_ready) break;
            lowc++;
            @(negedge clk);
        end
        chk("add_ready_low", lowc, 2);
        chk("add_top", int'(top_word), 8);
        chk("add_depth", int'(depth), 1);
        chk("add_carry", int'(carry), 0);

        // carry out of ADD, borrow out of SUB
        run(1, 9); run(1, 12); run(5, 0);
        chk("add2_top", int'(top_word), 5);
        chk("add2_carry", int'(carry), 1);
        run(1, 7); run(6, 0);
        chk("sub_top", int'(top_word), 14);
        chk("sub_carry", int'(carry), 1);
        chk("sub_depth", int'(depth), 2);

        // SWAP command sequence
        do_reset();
        run(1, 1); run(1, 2);
        issue(4, 0);
        op_valid = 1'b0;
        chk("swap_c1_mode", int'(stack_mode), 2);
        @(negedge clk);
        chk("swap_c2_mode", int'(stack_mode), 3);
        chk("swap_c2_in", int'(stack_in), 2);
        @(negedge clk);
        chk("swap_c3_mode", int'(stack_mode), 1);
        chk("swap_c3_in", int'(stack_in), 1);
        wait_idle();
        chk("swap_top", int'(top_word), 1);
        chk("swap_second", int'(second_word), 2);
        chk("swap_depth", int'(depth), 2);

        // underflow from empty
        do_reset();
        issue(2, 0);
        op_valid = 1'b0;
        chk("uf_flag", int'(err_underflow), 1);
        chk("uf_mode", int'(stack_mode), 0);

        // overflow on full stack, then illegal opcode
        do_reset();
        for (int i = 0; i < SZ; i++) run(1, i);
        issue(1, 5);
        chk("ovf_push_flag", int'(err_overflow), 1);
        chk("ovf_push_depth", int'(depth), SZ);
        issue(3, 0);
        chk("ovf_dup_flag", int'(err_overflow), 1);
        chk("ovf_dup_depth", int'(depth), SZ);
        issue(13, 0);
        op_valid = 1'b0;
        chk("ill_flag", int'(err_illegal), 1);
        chk("ill_uf", int'(err_underflow), 0);

        // reset in the middle of a SWAP
        do_reset();
        run(1, 1); run(1, 2);
        issue(4, 0);
        op_valid = 1'b0;
        @(negedge clk);
        chk("mid_cmd2_mode", int'(stack_mode), 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready", int'(op_ready), 1);
        chk("mid_rst_mode", int'(stack_mode), 0);
        chk("mid_rst_depth", int'(depth), 0);

        // back-to-back with op_valid held high
        @(negedge clk);
        a0 = dut_acc;
        issue(1, 4); issue(3, 0); issue(10, 0);
        wait_idle();
        chk("b2b_accepts", dut_acc - a0, 3);
        chk("b2b_top", int'(top_word), 11);
        chk("b2b_second", int'(second_word), 4);

        // randomized instruction stream
        do_reset();
        for (int n = 0; n < 300; n++) begin
            int r, o;
            r = $urandom_range(0, 99);
            if (r < 35) o = 1;
            else if (r < 40) o = $urandom_range(11, 15);
            else o = $urandom_range(0, 10);
            issue(o, $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                op_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            if ($urandom_range(0, 49) == 0) do_reset();
        end
        wait_idle();
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
